// File: rtl/l2_stats_collector_if.sv
// Snapshot dump stream for l2_stats_collector: tagged counter words under valid/ready.
// The producer drives valid/id/data and the consumer drives ready.
interface l2_stats_collector_if #(
    parameter int unsigned COUNT_WIDTH = 32
);
    logic                   dump_valid;
    logic                   dump_ready;
    logic [2:0]             dump_id;
    logic [COUNT_WIDTH-1:0] dump_data;

    modport master (
        output dump_valid,
        output dump_id,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_id,
        input  dump_data,
        output dump_ready
    );
endinterface

// File: rtl/l2_stats_collector.sv
// Saturating hit/miss/read/write event counters with a serial snapshot dump port.
// Define L2_STATS_TOTAL_EN to append a fifth word (id 4) carrying saturated HIT + MISS.
module l2_stats_collector #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 hit,
    input  logic                 miss,
    input  logic                 read,
    input  logic                 write,
    input  logic                 clear,
    input  logic                 dump_req,
    l2_stats_collector_if.master dump,
    output logic                 busy,
    output logic [3:0]           overflow
);

`ifdef L2_STATS_TOTAL_EN
    localparam int unsigned NumWords = 5;
`else
    localparam int unsigned NumWords = 4;
`endif
    localparam logic [2:0] LastId = 3'(NumWords - 1);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e state_q, state_d;

    logic [COUNT_WIDTH-1:0] cnt_q    [4];
    logic [COUNT_WIDTH-1:0] cnt_d    [4];
    logic [COUNT_WIDTH-1:0] cnt_post [4];
    logic [3:0]             ovf_q, ovf_d, ovf_post, strobe;

    logic [COUNT_WIDTH-1:0] shadow_q [NumWords];
    logic [COUNT_WIDTH-1:0] shadow_d [NumWords];
    logic [COUNT_WIDTH-1:0] snap     [NumWords];

    logic [2:0]             id_q, id_d, id_next;
    logic [COUNT_WIDTH-1:0] data_q, data_d, sel_data;
    logic                   capture, accept, last;

`ifdef L2_STATS_TOTAL_EN
    logic [COUNT_WIDTH:0]   total_sum;
`endif

    // Live counters: cnt_post is the value including this cycle's strobes, before clear.
    always_comb begin
        strobe = {write, read, miss, hit};
        for (int i = 0; i < 4; i++) begin
            if (strobe[i] && (cnt_q[i] != '1)) begin
                cnt_post[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end else begin
                cnt_post[i] = cnt_q[i];
            end
            ovf_post[i] = ovf_q[i] | (strobe[i] & (cnt_q[i] == '1));
            cnt_d[i]    = clear ? '0 : cnt_post[i];
        end
        ovf_d = clear ? 4'b0000 : ovf_post;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            snap[i] = cnt_post[i];
        end
`ifdef L2_STATS_TOTAL_EN
        total_sum = {1'b0, cnt_post[0]} + {1'b0, cnt_post[1]};
        snap[4]   = total_sum[COUNT_WIDTH] ? '1 : total_sum[COUNT_WIDTH-1:0];
`endif
    end

    assign capture = (state_q == StIdle) && dump_req;
    assign accept  = (state_q == StSend) && dump.dump_ready;
    assign last    = (id_q == LastId);
    assign id_next = id_q + 3'd1;

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (dump_req) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (accept && last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        dump.dump_valid = (state_q == StSend);
        busy            = (state_q == StSend);
        dump.dump_id    = id_q;
        dump.dump_data  = data_q;
        overflow        = ovf_q;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NumWords; i++) begin
            if (id_next == 3'(i)) begin
                sel_data = shadow_q[i];
            end
        end
    end

    // Shadow and output word registers; the word is preloaded so id/data stay registered.
    always_comb begin
        for (int i = 0; i < NumWords; i++) begin
            shadow_d[i] = capture ? snap[i] : shadow_q[i];
        end
        id_d   = id_q;
        data_d = data_q;
        if (capture) begin
            id_d   = 3'd0;
            data_d = snap[0];
        end else if (accept) begin
            if (last) begin
                id_d   = 3'd0;
                data_d = '0;
            end else begin
                id_d   = id_next;
                data_d = sel_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            for (int i = 0; i < NumWords; i++) begin
                shadow_q[i] <= '0;
            end
            ovf_q  <= 4'b0000;
            id_q   <= 3'd0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            for (int i = 0; i < NumWords; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
            ovf_q  <= ovf_d;
            id_q   <= id_d;
            data_q <= data_d;
        end
    end

endmodule
